// File: rtl/csa_multiplier_4x4_pkg.sv
// Shared constants for the 4x4 carry-save array multiplier.
package csa_mul_pkg;
  localparam int OP_W    = 4;
  localparam int RES_W   = 8;
  localparam int LATENCY = 3;
endpackage

// File: rtl/csa_multiplier_4x4_if.sv
// Operand/result handshake bundle for csa_multiplier_4x4.
interface csa_multiplier_4x4_if;
  import csa_mul_pkg::*;

  logic [OP_W-1:0]  src1;
  logic [OP_W-1:0]  src2;
  logic             start;
  logic [RES_W-1:0] result;
  logic             valid;

  modport master (output src1, output src2, output start, input result, input valid);
  modport slave  (input src1, input src2, input start, output result, output valid);
endinterface

// File: rtl/csa_multiplier_4x4_full_adder.sv
// One-bit full adder; used as a half adder by tying cin low.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/csa_multiplier_4x4.sv
// Unsigned 4x4 multiplier: operand register, carry-save array, ripple CPA.
// Fixed 3-cycle latency, one operation accepted per clock.
module csa_multiplier_4x4
  import csa_mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  csa_multiplier_4x4_if.slave  bus
);

  logic [OP_W-1:0]          src1_p0_q, src1_p0_d;
  logic [OP_W-1:0]          src2_p0_q, src2_p0_d;
  logic                     vld_p0_q, vld_p0_d;

  logic [OP_W-1:0][OP_W-1:0] pp;
  logic [OP_W-2:0]          r1_s, r1_c, r2_s, r2_c, r3_s, r3_c;
  logic [OP_W-1:0]          r1_row, r2_row;

  logic [OP_W-2:0]          sum_p1_q, sum_p1_d;
  logic [OP_W-2:0]          carry_p1_q, carry_p1_d;
  logic [OP_W-1:0]          lo_p1_q, lo_p1_d;
  logic                     vld_p1_q, vld_p1_d;

  logic [OP_W-2:0]          cpa_s, cpa_co;
  logic [RES_W-1:0]         result_p2_q, result_p2_d;
  logic                     vld_p2_q, vld_p2_d;

  // Stage 0: capture operands only on start
  always_comb begin
    src1_p0_d = bus.start ? bus.src1 : src1_p0_q;
    src2_p0_d = bus.start ? bus.src2 : src2_p0_q;
    vld_p0_d  = bus.start;
  end

  // Stage 1: partial products reduced by three carry-save rows
  always_comb begin
    pp = '0;
    for (int i = 0; i < OP_W; i++)
      for (int j = 0; j < OP_W; j++)
        pp[i][j] = src1_p0_q[j] & src2_p0_q[i];
  end

  assign r1_row = {pp[1][3], r1_s};
  assign r2_row = {pp[2][3], r2_s};

  for (genvar j = 0; j < OP_W-1; j++) begin : g_csa
    full_adder u_row1 (.a(pp[0][j+1]),  .b(pp[1][j]), .cin(1'b0),    .sum(r1_s[j]), .cout(r1_c[j]));
    full_adder u_row2 (.a(r1_row[j+1]), .b(pp[2][j]), .cin(r1_c[j]), .sum(r2_s[j]), .cout(r2_c[j]));
    full_adder u_row3 (.a(r2_row[j+1]), .b(pp[3][j]), .cin(r2_c[j]), .sum(r3_s[j]), .cout(r3_c[j]));
  end

  // Sum/carry vectors both carry weights 4..6; bits 3..0 leave the array final.
  always_comb begin
    sum_p1_d   = {pp[3][3], r3_s[2:1]};
    carry_p1_d = r3_c;
    lo_p1_d    = {r3_s[0], r2_s[0], r1_s[0], pp[0][0]};
    vld_p1_d   = vld_p0_q;
  end

  // Stage 2: ripple carry-propagate merge of the upper bits
  for (genvar k = 0; k < OP_W-1; k++) begin : g_cpa
    if (k == 0) begin : g_lsb
      full_adder u_cpa (.a(sum_p1_q[k]), .b(carry_p1_q[k]), .cin(1'b0),
                        .sum(cpa_s[k]), .cout(cpa_co[k]));
    end else begin : g_bit
      full_adder u_cpa (.a(sum_p1_q[k]), .b(carry_p1_q[k]), .cin(cpa_co[k-1]),
                        .sum(cpa_s[k]), .cout(cpa_co[k]));
    end
  end

  always_comb begin
    result_p2_d = vld_p1_q ? {cpa_co[OP_W-2], cpa_s, lo_p1_q} : result_p2_q;
    vld_p2_d    = vld_p1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src1_p0_q   <= '0;
      src2_p0_q   <= '0;
      vld_p0_q    <= 1'b0;
      sum_p1_q    <= '0;
      carry_p1_q  <= '0;
      lo_p1_q     <= '0;
      vld_p1_q    <= 1'b0;
      result_p2_q <= '0;
      vld_p2_q    <= 1'b0;
    end else begin
      src1_p0_q   <= src1_p0_d;
      src2_p0_q   <= src2_p0_d;
      vld_p0_q    <= vld_p0_d;
      sum_p1_q    <= sum_p1_d;
      carry_p1_q  <= carry_p1_d;
      lo_p1_q     <= lo_p1_d;
      vld_p1_q    <= vld_p1_d;
      result_p2_q <= result_p2_d;
      vld_p2_q    <= vld_p2_d;
    end
  end

  assign bus.result = result_p2_q;
  assign bus.valid  = vld_p2_q;

endmodule

// File: tb/tb_csa_multiplier_4x4.sv
// Directed bench for csa_multiplier_4x4: reset, latency, boundary products,
// streaming, reset mid-operation and an exhaustive operand sweep.
module tb_csa_multiplier_4x4;
  import csa_mul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  csa_multiplier_4x4_if bus_if ();

  csa_multiplier_4x4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands for exactly one rising edge; returns at the falling edge after it.
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    bus_if.src1  = a;
    bus_if.src2  = b;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  // Count falling edges until valid is seen (bounded); -1 when it never arrives.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(negedge clk);
      if (bus_if.valid === 1'b1) lat = k;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp);
    int lat;
    issue(a, b);
    wait_valid(lat);
    chk({tag, "_lat"}, 8'(lat), 8'(LATENCY - 1));
    chk(tag, bus_if.result, exp);
  endtask

  initial begin
    int lat;
    rst          = 1'b1;
    bus_if.src1  = '0;
    bus_if.src2  = '0;
    bus_if.start = 1'b0;
    #1;
    chk("rst_result", bus_if.result, 8'd0);
    chk("rst_valid", {7'd0, bus_if.valid}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_valid", {7'd0, bus_if.valid}, 8'd0);
    end

    // single op 3*5 with exact latency and hold behaviour
    issue(4'd3, 4'd5);
    @(negedge clk);
    chk("single_early", {7'd0, bus_if.valid}, 8'd0);
    @(negedge clk);
    chk("single_valid", {7'd0, bus_if.valid}, 8'd1);
    chk("single_result", bus_if.result, 8'd15);
    @(negedge clk);
    chk("single_drop", {7'd0, bus_if.valid}, 8'd0);
    chk("single_hold", bus_if.result, 8'd15);

    // asynchronous reset between edges clears the output at once
    #2 rst = 1'b1;
    #1;
    chk("async_result", bus_if.result, 8'd0);
    chk("async_valid", {7'd0, bus_if.valid}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("b15x15", 4'd15, 4'd15, 8'd225);
    run_op("b0x9",   4'd0,  4'd9,  8'd0);
    run_op("b9x0",   4'd9,  4'd0,  8'd0);
    run_op("b1x15",  4'd1,  4'd15, 8'd15);
    run_op("b8x8",   4'd8,  4'd8,  8'd64);
    run_op("b10x12", 4'd10, 4'd12, 8'd120);

    // back-to-back streaming
    @(negedge clk);
    bus_if.src1 = 4'd2;  bus_if.src2 = 4'd3;  bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.src1 = 4'd7;  bus_if.src2 = 4'd7;
    @(negedge clk);
    bus_if.src1 = 4'd15; bus_if.src2 = 4'd14;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("stream0_valid", {7'd0, bus_if.valid}, 8'd1);
    chk("stream0_result", bus_if.result, 8'd6);
    @(negedge clk);
    chk("stream1_valid", {7'd0, bus_if.valid}, 8'd1);
    chk("stream1_result", bus_if.result, 8'd49);
    @(negedge clk);
    chk("stream2_valid", {7'd0, bus_if.valid}, 8'd1);
    chk("stream2_result", bus_if.result, 8'd210);
    @(negedge clk);
    chk("stream_end", {7'd0, bus_if.valid}, 8'd0);

    // reset mid-operation discards in-flight work; start during reset ignored
    @(negedge clk);
    bus_if.src1 = 4'd6; bus_if.src2 = 4'd6; bus_if.start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus_if.src1 = 4'd7; bus_if.src2 = 4'd7;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("midrst_in", {7'd0, bus_if.valid}, 8'd0);
    end
    rst = 1'b0;
    bus_if.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_after", {7'd0, bus_if.valid}, 8'd0);
    end
    chk("midrst_result", bus_if.result, 8'd0);
    run_op("post_rst_4x5", 4'd4, 4'd5, 8'd20);

    // exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(4'(a), 4'(b));
        wait_valid(lat);
        chk("exh_lat", 8'(lat), 8'(LATENCY - 1));
        chk("exh", bus_if.result, 8'(a * b));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csa_multiplier_4x4.md
Name: csa_multiplier_4x4

Overview:
- Unsigned 4x4-bit multiplier with an 8-bit product, built as a carry-save adder (CSA) array followed by a ripple carry-propagate adder.
- Start/valid handshake; fully pipelined, fixed 3-cycle latency, one new operation accepted per clock.
- Sits as an arithmetic leaf unit driven by a controller that pulses start and waits for valid.

Parameters:
- none (operand width fixed at 4, result width fixed at 8)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- src1  input  4  multiplicand, unsigned
- src2  input  4  multiplier, unsigned
- start  input  1  operand-valid strobe; src1/src2 sampled on the rising edge where start=1
- result  output  8  product src1*src2, unsigned
- valid  output  1  high for the cycle(s) in which result holds a newly completed product

Behaviour:
- Reset (rst=1, asynchronous): all pipeline registers cleared; result=8'h00, valid=0. Reset has priority over all other inputs.
- Stage 0 (edge E0, start=1): register src1, src2 and a stage-valid bit. Operands are not sampled when start=0.
- Stage 1 (edge E0+1):
  - Partial products pp[i][j] = src1[j] & src2[i].
  - Reduced through the CSA array (rows of full/half adders; carries passed diagonally, never rippled within a row).
  - Register the sum vector, the carry vector and the low product bits already final.
- Stage 2 (edge E0+2):
  - Ripple CPA merges the sum and carry vectors into bits [7:4]; product bits [3:0] are already final from the array.
  - Register result; valid=1.
- Latency: valid and the corresponding result appear on edge E0+2, visible in the cycle after it.
- valid is a 1-cycle pulse per accepted start.
- result holds its last value until the next completed product. It is not cleared when valid drops.
- Back-to-back: start=1 on consecutive edges yields valid=1 on consecutive cycles, with products in issue order.
- start held permanently high gives continuous valid with a product every cycle.
- No overflow is possible: 15*15=225 fits in 8 bits.
- Any operand is 0 -> result 0.
- Reset asserted mid-operation: all in-flight operations are discarded. valid stays 0 until a new start is issued after reset is released.
- start asserted during reset is ignored.
- No X propagation: every register has a reset value.

Decomposition:
- Shared package `csa_mul_pkg`: constants OP_W=4, RES_W=8, LATENCY=3.
- One natural sub-module: `full_adder` (a, b, cin -> sum, cout). It is instantiated for every CSA cell and every CPA bit.
- Half-adder positions use `full_adder` with cin tied to 0.

Test Plan:
- Reset: assert rst asynchronously between edges -> result=0 and valid=0 immediately; release rst, start=0 -> valid stays 0.
- Single op: src1=3, src2=5, 1-cycle start at edge E0 -> valid=1 after edge E0+2 with result=15; valid=0 the next cycle, result still 15.
- Boundary values:
  - 15*15 -> 225
  - 0*9 -> 0
  - 9*0 -> 0
  - 1*15 -> 15
  - 8*8 -> 64
  - 10*12 -> 120
- Exhaustive: all 256 (src1, src2) pairs, each with a 1-cycle start and a wait for valid -> result == src1*src2 for every pair; error count must be 0.
- Back-to-back streaming: start held high, operands (2,3), (7,7), (15,14) on consecutive edges -> valid high for 3 consecutive cycles with results 6, 49, 210 in order.
- Reset mid-op: start (6,6), assert rst one cycle later -> no valid pulse. Then (4,5) after reset release -> result 20 with correct latency.
